facto_master: RTL and testbench
===============================

// Module: facto_master
// PURPOSE
//  Bus-master sequencer upstream of the memory-mapped factorial core. Accepts one operand per
//  request and runs the full register programme on the core's slave port:
//  operand, intrEn, opstart, wait for done, result_h, result_l, opclear.
//  Returns the 128-bit result on a valid/ready response channel, with a timeout guard.
// PARAMETERS
//  BASE_ADDR  16'h7000  base of core register window; offsets 0x00 opstart, 0x08 opclear,
//                       0x10 opdone, 0x18 intrEn, 0x20 operand, 0x28 result_h, 0x30 result_l
//  TIMEOUT    2048      max cycles in WAIT before abort (>=2)
//  POLL_GAP   4         idle cycles between opdone polls in polling mode (>=0)
// PORTS
//  clk          in   1    clock, all logic on rising edge
//  reset        in   1    synchronous, active-high reset
//  req_valid    in   1    operand request valid
//  req_ready    out  1    high only in IDLE
//  req_operand  in   64   factorial operand N
//  req_use_intr in   1    1: wait on intr_in; 0: poll opdone
//  rsp_valid    out  1    result valid, held until rsp_ready
//  rsp_ready    in   1    consumer accepts result
//  rsp_result   out  128  {result_h,result_l}; 0 on timeout
//  rsp_timeout  out  1    1 = operation aborted by TIMEOUT
//  m_sel        out  1    core chip select
//  m_wr         out  1    1 write, 0 read
//  m_addr       out  16   BASE_ADDR + offset
//  m_wdata      out  64   write data to core s_din
//  m_rdata      in   64   core s_dout
//  intr_in      in   1    core interrupt, level
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1, rsp_valid=0, rsp_result=0, rsp_timeout=0, m_sel=0,
//    m_wr=0, m_addr=BASE_ADDR, m_wdata=0. Reset mid-operation aborts immediately.
//    No opclear is issued; the core must be reset alongside.
//  - All m_* outputs are registered. Each bus access occupies exactly one cycle with m_sel=1.
//  - Read data: m_rdata is sampled on the cycle after the read access cycle, while m_sel=0
//    and m_addr is still held.
//  - FSM: IDLE -(req_valid&req_ready; latch operand, use_intr)-> WR_OPND (wr 0x20, operand)
//    -> WR_INTR (wr 0x18, {63'b0,use_intr}) -> WR_START (wr 0x00, 1) -> WAIT.
//  - WAIT, interrupt mode: leave when intr_in=1.
//  - WAIT, polling mode: cycle POLL (rd 0x10) -> POLL_CAP. If m_rdata[0]=1, leave WAIT;
//    otherwise idle POLL_GAP cycles and repeat.
//  - After WAIT: RD_H (rd 0x28) -> CAP_H (latch high) -> RD_L (rd 0x30) -> CAP_L (latch low)
//    -> WR_CLR (wr 0x08, 1) -> WR_CLR0 (wr 0x08, 0) -> RESP.
//  - RESP: rsp_valid=1, rsp_result/rsp_timeout stable. On rsp_ready go to IDLE;
//    rsp_valid drops the next cycle.
//  - Timeout: a counter starts at 0 on entry to WAIT and increments each WAIT cycle,
//    poll cycles included. On reaching TIMEOUT-1 without done: go to WR_CLR,
//    rsp_timeout=1, result forced to 0.
//  - Simultaneous done and TIMEOUT-1 in the same cycle: done wins, no timeout.
//  - req_valid outside IDLE is ignored (req_ready=0); no queuing.
//  - Latency, interrupt mode, intr_in high on first WAIT cycle: req handshake ->
//    rsp_valid = 10 cycles.
//  - An interrupt already high in IDLE is ignored; only intr_in in WAIT counts.
// TESTING (bench uses a behavioural core model: computes N!, asserts done after D cycles)
//  1 reset asserted 3 cycles -> all outputs at reset values, req_ready=1, m_sel never 1
//  2 N=20, intr mode, D=50 -> bus sequence 0x7020,0x7018(1),0x7000(1), then reads 0x7028,
//    0x7030, writes 0x7008 1 then 0; rsp_result=128'h0_21C3677C82B40000, rsp_timeout=0
//  3 N=0, then N=1, polling mode, POLL_GAP=4 -> rsp_result=1 both; polls spaced 6 cycles;
//    0x7018 written 0
//  4 model never asserts done, TIMEOUT=64 -> rsp_timeout=1, rsp_result=0, opclear still
//    issued, req_ready back after rsp handshake
//  5 rsp_ready held low 20 cycles -> rsp_valid/result stable; new req_valid ignored until
//    accepted
//  6 reset pulsed during WAIT -> IDLE next cycle, m_sel=0; fresh N=5 request returns 120

Source files
------------

// File: rtl/facto_master.sv
// Bus-master sequencer for the memory-mapped factorial core: programmes one operand,
// waits for completion (interrupt or polling, with timeout) and returns the 128-bit result.
module facto_master #(
    parameter logic [15:0] BASE_ADDR = 16'h7000,
    parameter int          TIMEOUT   = 2048,
    parameter int          POLL_GAP  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [63:0]   req_operand_i,
    input  logic          req_use_intr_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [127:0]  rsp_result_o,
    output logic          rsp_timeout_o,
    output logic          m_sel_o,
    output logic          m_wr_o,
    output logic [15:0]   m_addr_o,
    output logic [63:0]   m_wdata_o,
    input  logic [63:0]   m_rdata_i,
    input  logic          intr_in_i,
    output logic [3:0]    dbg_state_o
);

    // Request: transfer when req_valid_i && req_ready_o on a rising edge.
    // Response: rsp_valid_o holds with stable data until a rising edge sees rsp_ready_i.
    typedef enum logic [3:0] {
        ST_IDLE, ST_WR_OPND, ST_WR_INTR, ST_WR_START, ST_WAIT, ST_POLL, ST_POLL_CAP,
        ST_RD_H, ST_CAP_H, ST_RD_L, ST_CAP_L, ST_WR_CLR, ST_WR_CLR0, ST_RESP
    } state_t;

    state_t         state_q, state_d;
    logic           m_sel_q, m_sel_d, m_wr_q, m_wr_d;
    logic [15:0]    m_addr_q, m_addr_d;
    logic [63:0]    m_wdata_q, m_wdata_d;
    logic [63:0]    opnd_q, opnd_d, res_h_q, res_h_d, res_l_q, res_l_d;
    logic           use_intr_q, use_intr_d, abort_q, abort_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [15:0]    gap_q, gap_d;
    logic [127:0]   rsp_result_q, rsp_result_d;
    logic           rsp_timeout_q, rsp_timeout_d;
    logic           done;

    // Interrupt mode only listens in WAIT; polling mode only trusts the captured opdone read.
    assign done = use_intr_q ? (state_q == ST_WAIT && intr_in_i)
                             : (state_q == ST_POLL_CAP && m_rdata_i[0]);

    always_comb begin
        state_d       = state_q;
        opnd_d        = opnd_q;
        use_intr_d    = use_intr_q;
        abort_d       = abort_q;
        cnt_d         = cnt_q;
        gap_d         = gap_q;
        res_h_d       = res_h_q;
        res_l_d       = res_l_q;
        rsp_result_d  = rsp_result_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            ST_IDLE: if (req_valid_i) begin
                opnd_d     = req_operand_i;
                use_intr_d = req_use_intr_i;
                abort_d    = 1'b0;
                state_d    = ST_WR_OPND;
            end
            ST_WR_OPND:  state_d = ST_WR_INTR;
            ST_WR_INTR:  state_d = ST_WR_START;
            ST_WR_START: begin
                cnt_d   = '0;
                gap_d   = '0;
                state_d = use_intr_q ? ST_WAIT : ST_POLL;
            end
            ST_WAIT, ST_POLL, ST_POLL_CAP: begin
                cnt_d = cnt_q + 32'd1;
                if (done) begin
                    state_d = ST_RD_H;
                end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    state_d = ST_WR_CLR;
                end else if (state_q == ST_POLL) begin
                    state_d = ST_POLL_CAP;
                end else if (state_q == ST_POLL_CAP) begin
                    gap_d   = '0;
                    state_d = (POLL_GAP == 0) ? ST_POLL : ST_WAIT;
                end else if (!use_intr_q) begin
                    if (gap_q == 16'(POLL_GAP - 1)) state_d = ST_POLL;
                    else                           gap_d   = gap_q + 16'd1;
                end
            end
            ST_RD_H:  state_d = ST_CAP_H;
            ST_CAP_H: begin
                res_h_d = m_rdata_i;
                state_d = ST_RD_L;
            end
            ST_RD_L:  state_d = ST_CAP_L;
            ST_CAP_L: begin
                res_l_d = m_rdata_i;
                state_d = ST_WR_CLR;
            end
            ST_WR_CLR:  state_d = ST_WR_CLR0;
            ST_WR_CLR0: begin
                rsp_result_d  = abort_q ? 128'd0 : {res_h_q, res_l_q};
                rsp_timeout_d = abort_q;
                state_d       = ST_RESP;
            end
            ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are registered from the state being entered; address holds between accesses
    // so read data can be captured the cycle after the access.
    always_comb begin
        m_sel_d   = 1'b0;
        m_wr_d    = 1'b0;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        case (state_d)
            ST_WR_OPND:  begin m_sel_d = 1'b1; m_wr_d = 1'b1; m_addr_d = BASE_ADDR + 16'h0020; m_wdata_d = opnd_d; end
            ST_WR_INTR:  begin m_sel_d = 1'b1; m_wr_d = 1'b1; m_addr_d = BASE_ADDR + 16'h0018; m_wdata_d = {63'd0, use_intr_d}; end
            ST_WR_START: begin m_sel_d = 1'b1; m_wr_d = 1'b1; m_addr_d = BASE_ADDR;           m_wdata_d = 64'd1; end
            ST_POLL:     begin m_sel_d = 1'b1; m_addr_d = BASE_ADDR + 16'h0010; end
            ST_RD_H:     begin m_sel_d = 1'b1; m_addr_d = BASE_ADDR + 16'h0028; end
            ST_RD_L:     begin m_sel_d = 1'b1; m_addr_d = BASE_ADDR + 16'h0030; end
            ST_WR_CLR:   begin m_sel_d = 1'b1; m_wr_d = 1'b1; m_addr_d = BASE_ADDR + 16'h0008; m_wdata_d = 64'd1; end
            ST_WR_CLR0:  begin m_sel_d = 1'b1; m_wr_d = 1'b1; m_addr_d = BASE_ADDR + 16'h0008; m_wdata_d = 64'd0; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            m_sel_q       <= 1'b0;
            m_wr_q        <= 1'b0;
            m_addr_q      <= BASE_ADDR;
            m_wdata_q     <= '0;
            opnd_q        <= '0;
            use_intr_q    <= 1'b0;
            abort_q       <= 1'b0;
            cnt_q         <= '0;
            gap_q         <= '0;
            res_h_q       <= '0;
            res_l_q       <= '0;
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            m_sel_q       <= m_sel_d;
            m_wr_q        <= m_wr_d;
            m_addr_q      <= m_addr_d;
            m_wdata_q     <= m_wdata_d;
            opnd_q        <= opnd_d;
            use_intr_q    <= use_intr_d;
            abort_q       <= abort_d;
            cnt_q         <= cnt_d;
            gap_q         <= gap_d;
            res_h_q       <= res_h_d;
            res_l_q       <= res_l_d;
            rsp_result_q  <= rsp_result_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_result_o  = rsp_result_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign m_sel_o       = m_sel_q;
    assign m_wr_o        = m_wr_q;
    assign m_addr_o      = m_addr_q;
    assign m_wdata_o     = m_wdata_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_facto_master.sv
// Directed bench for facto_master with a behavioural factorial core on the slave bus.
module tb_facto_master;

  localparam int TIMEOUT  = 64;
  localparam int POLL_GAP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_use_intr = 1'b0;
  logic [63:0]   req_operand = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [127:0]  rsp_result;
  logic          m_sel, m_wr, intr_in;
  logic [15:0]   m_addr;
  logic [63:0]   m_wdata, m_rdata;
  logic [3:0]    dbg_state;

  always #5 clk = ~clk;

  facto_master #(.BASE_ADDR(16'h7000), .TIMEOUT(TIMEOUT), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operand_i(req_operand),
    .req_use_intr_i(req_use_intr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_timeout_o(rsp_timeout),
    .m_sel_o(m_sel), .m_wr_o(m_wr), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_rdata_i(m_rdata), .intr_in_i(intr_in), .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // behavioural core
  logic [63:0]  c_opnd;
  logic         c_intr_en, c_done, c_busy;
  logic [127:0] c_res;
  int           c_cnt;
  int           d_cycles = 50;
  bit           never_done = 1'b0;

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r = 128'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 128'(i);
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      c_opnd <= '0; c_intr_en <= 1'b0; c_done <= 1'b0; c_busy <= 1'b0; c_res <= '0; c_cnt <= 0;
    end else begin
      if (c_busy && !never_done) begin
        if (c_cnt <= 1) begin c_done <= 1'b1; c_busy <= 1'b0; end
        else c_cnt <= c_cnt - 1;
      end
      if (m_sel && m_wr) begin
        case (m_addr)
          16'h7020: c_opnd <= m_wdata;
          16'h7018: c_intr_en <= m_wdata[0];
          16'h7000: if (m_wdata[0]) begin
            c_res  <= fact(c_opnd);
            c_done <= 1'b0;
            if (d_cycles == 0 && !never_done) c_done <= 1'b1;
            else begin c_busy <= 1'b1; c_cnt <= d_cycles; end
          end
          16'h7008: if (m_wdata[0]) c_done <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign intr_in = c_done & c_intr_en;

  always_comb begin
    m_rdata = '0;
    case (m_addr)
      16'h7010: m_rdata = {63'd0, c_done};
      16'h7028: m_rdata = c_res[127:64];
      16'h7030: m_rdata = c_res[63:0];
      default:  m_rdata = '0;
    endcase
  end

  // bus log: {wr, addr, wdata (0 for reads)} plus cycle stamps of opdone polls
  logic [80:0] bus_q[$];
  logic [80:0] exp_q[$];
  int          poll_cyc[$];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_sel) begin
      bus_q.push_back({m_wr, m_addr, m_wr ? m_wdata : 64'd0});
      if (!m_wr && m_addr == 16'h7010) poll_cyc.push_back(cyc);
    end
  end

  task automatic do_req(input logic [63:0] n, input bit use_intr, input int hold,
                        input logic [127:0] exp_res, input bit exp_to, output int lat);
    int w = 0;
    int bus_before;
    @(negedge clk);
    while (!req_ready && w < 200) begin @(negedge clk); w++; end
    check("req_ready_idle", req_ready, 1'b1);
    req_operand = n; req_use_intr = use_intr; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 5000) begin @(negedge clk); lat++; end
    check("rsp_arrived", rsp_valid, 1'b1);
    check("rsp_result", rsp_result, exp_res);
    check("rsp_timeout", rsp_timeout, exp_to);
    bus_before = bus_q.size();
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_operand = 64'd7;
      @(negedge clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_result", rsp_result, exp_res);
      check("hold_ready_low", req_ready, 1'b0);
    end
    if (hold > 0) check("hold_no_bus", bus_q.size(), bus_before);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_dropped", rsp_valid, 1'b0);
    check("req_ready_back", req_ready, 1'b1);
  endtask

  initial begin
    int lat;
    logic [63:0] intr_wd;
    bit seen_clr1, seen_clr0;

    // 1: reset held three cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_msel", m_sel, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_result", rsp_result, 128'd0);
    check("rst_timeout", rsp_timeout, 1'b0);
    check("rst_mwr", m_wr, 1'b0);
    check("rst_maddr", m_addr, 16'h7000);
    check("rst_mwdata", m_wdata, 64'd0);
    check("rst_state", dbg_state, 4'd0);

    // 2: N=20 interrupt mode, full bus sequence
    d_cycles = 50; bus_q.delete();
    do_req(64'd20, 1'b1, 0, 128'h21C3677C82B40000, 1'b0, lat);
    exp_q = '{ {1'b1, 16'h7020, 64'd20}, {1'b1, 16'h7018, 64'd1}, {1'b1, 16'h7000, 64'd1},
               {1'b0, 16'h7028, 64'd0},  {1'b0, 16'h7030, 64'd0},
               {1'b1, 16'h7008, 64'd1},  {1'b1, 16'h7008, 64'd0} };
    check("seq_len", bus_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++) check("seq_entry", bus_q[i], exp_q[i]);

    // minimum latency: interrupt already present on the first WAIT cycle
    d_cycles = 0;
    do_req(64'd3, 1'b1, 0, 128'd6, 1'b0, lat);
    check("latency", lat, 10);

    // 3: polling mode, N=0 and N=1
    d_cycles = 10;
    for (int k = 0; k < 2; k++) begin
      bus_q.delete(); poll_cyc.delete();
      do_req(64'(k), 1'b0, 0, 128'd1, 1'b0, lat);
      intr_wd = '1;
      foreach (bus_q[i]) if (bus_q[i][80] && bus_q[i][79:64] == 16'h7018) intr_wd = bus_q[i][63:0];
      check("intr_en_wr0", intr_wd, 64'd0);
      check("poll_count", poll_cyc.size() >= 2, 1'b1);
      for (int i = 1; i < poll_cyc.size(); i++) check("poll_gap", poll_cyc[i] - poll_cyc[i-1], 6);
    end

    // 4: core never finishes
    never_done = 1'b1; bus_q.delete();
    do_req(64'd6, 1'b0, 0, 128'd0, 1'b1, lat);
    seen_clr1 = 1'b0; seen_clr0 = 1'b0;
    foreach (bus_q[i]) begin
      if (bus_q[i] == {1'b1, 16'h7008, 64'd1}) seen_clr1 = 1'b1;
      if (bus_q[i] == {1'b1, 16'h7008, 64'd0}) seen_clr0 = 1'b1;
    end
    check("to_clr1", seen_clr1, 1'b1);
    check("to_clr0", seen_clr0, 1'b1);
    never_done = 1'b0;

    // 5: consumer stalls 20 cycles while a new request is offered
    d_cycles = 3;
    do_req(64'd4, 1'b1, 20, 128'd24, 1'b0, lat);

    // 6: reset in the middle of WAIT
    d_cycles = 200;
    @(negedge clk);
    req_operand = 64'd9; req_use_intr = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_wait_state", dbg_state, 4'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_msel", m_sel, 1'b0);
    check("post_rst_ready", req_ready, 1'b1);
    check("post_rst_valid", rsp_valid, 1'b0);
    check("post_rst_state", dbg_state, 4'd0);
    d_cycles = 5;
    do_req(64'd5, 1'b1, 0, 128'd120, 1'b0, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
